// File: rtl/mem_arbiter.sv
// Two-port arbiter sequencing accesses to a 64x8 async SRAM as setup -> strobe -> hold.
// Define MEM_ARBITER_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module mem_arbiter #(
  parameter int AW   = 6,
  parameter int DW   = 8,
  parameter int WAIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_ack,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_ack,
  output logic [AW-1:0] ram_addr,
  inout  wire  [DW-1:0] ram_data,
  output logic          ram_cs_n,
  output logic          ram_we_n,
  output logic          ram_oe_n,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  localparam logic [2:0] WAIT_CNT = 3'(WAIT);

  state_t        state_reg, state_next;
  logic [2:0]    cnt_reg, cnt_next;
  logic          port_reg;
  logic          we_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;

  logic [1:0]    req;
  logic [1:0]    we_in;
  logic [AW-1:0] addr_in  [2];
  logic [DW-1:0] wdata_in [2];
  logic [DW-1:0] rdata_reg [2];
  logic [1:0]    ack;
  logic          grant_port;
  logic          grant;
  logic          strobe_last;

  assign req         = {p1_req, p0_req};
  assign we_in       = {p1_we, p0_we};
  assign addr_in[0]  = p0_addr;
  assign addr_in[1]  = p1_addr;
  assign wdata_in[0] = p0_wdata;
  assign wdata_in[1] = p1_wdata;

  assign grant       = (state_reg == IDLE) && (req != 2'b00);
  assign strobe_last = (state_reg == STROBE) && (cnt_reg == WAIT_CNT);

`ifdef MEM_ARBITER_RR_EN
  logic rr_ptr_reg;

  // Pointer names the port that wins a tie; it flips to the other port on every grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rr_ptr_reg <= 1'b0;
    else if (grant) rr_ptr_reg <= ~grant_port;
  end

  always_comb begin
    grant_port = 1'b0;
    if (req == 2'b11) grant_port = rr_ptr_reg;
    else              grant_port = req[1];
  end
`else
  always_comb begin
    grant_port = 1'b0;
    if (!req[0]) grant_port = req[1];
  end
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE:   if (grant) state_next = SETUP;
      SETUP:  begin
        state_next = STROBE;
        cnt_next   = 3'd0;
      end
      STROBE: begin
        if (strobe_last) state_next = DONE;
        else             cnt_next   = cnt_reg + 3'd1;
      end
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
      port_reg  <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (grant) begin
        port_reg  <= grant_port;
        we_reg    <= we_in[grant_port];
        addr_reg  <= addr_in[grant_port];
        wdata_reg <= wdata_in[grant_port];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      // Read data is captured on the edge that ends the strobe, while OE is still low.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          rdata_reg[gi] <= '0;
        else if (strobe_last && !we_reg && (port_reg == 1'(gi)))
          rdata_reg[gi] <= ram_data;
      end
      assign ack[gi] = (state_reg == DONE) && (port_reg == 1'(gi));
    end
  endgenerate

  assign p0_rdata = rdata_reg[0];
  assign p1_rdata = rdata_reg[1];
  assign p0_ack   = ack[0];
  assign p1_ack   = ack[1];

  // Strobes decode straight from state so an async reset releases them at once.
  assign ram_addr = addr_reg;
  assign ram_cs_n = (state_reg == IDLE);
  assign ram_oe_n = !((state_reg == STROBE) && !we_reg);
  assign ram_we_n = !((state_reg == STROBE) && we_reg);
  assign ram_data = (we_reg && (state_reg != IDLE)) ? wdata_reg : {DW{1'bz}};
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter with a behavioural SRAM and memory model.
// Expected arbitration order follows MEM_ARBITER_RR_EN when it is defined.
module tb_mem_arbiter;
  localparam int AW   = 6;
  localparam int DW   = 8;
  localparam int WAIT = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          p0_ack, p1_ack;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;
  logic          ram_cs_n, ram_we_n, ram_oe_n, busy;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] sram  [64];
  logic [DW-1:0] model [64];

  mem_arbiter #(.AW(AW), .DW(DW), .WAIT(WAIT)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_ack(p1_ack),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_cs_n(ram_cs_n), .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n), .busy(busy)
  );

  always #5 clk = ~clk;

  // Async SRAM: drives data while selected and output-enabled, latches on WE rising.
  assign ram_data = (!ram_cs_n && !ram_oe_n) ? sram[ram_addr] : {DW{1'bz}};
  always @(posedge ram_we_n) if (!ram_cs_n) sram[ram_addr] = ram_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("we_oe_exclusive", 32'(ram_we_n | ram_oe_n), 32'd1);
      check("single_ack", 32'(p0_ack & p1_ack), 32'd0);
    end
  end

  // One access on one port; latency counted in edges from the cycle the request appears.
  task automatic access(input bit port, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    int n, oe_cnt, we_cnt;
    bit got;
    @(posedge clk); #1;
    if (port) begin p1_req = 1; p1_we = we; p1_addr = a; p1_wdata = d; end
    else      begin p0_req = 1; p0_we = we; p0_addr = a; p0_wdata = d; end
    n = 0; got = 0; oe_cnt = 0; we_cnt = 0;
    while (!got && n < 20) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (!ram_oe_n) oe_cnt++;
      if (!ram_we_n) we_cnt++;
      if (we && busy) check("wdata_driven", 32'(ram_data), 32'(d));
      if (port ? p1_ack : p0_ack) got = 1;
    end
    check("ack_latency", n, WAIT + 3);
    check("oe_cycles", oe_cnt, we ? 0 : WAIT + 1);
    check("we_cycles", we_cnt, we ? WAIT + 1 : 0);
    if (!we) check(port ? "p1_rdata" : "p0_rdata", 32'(port ? p1_rdata : p0_rdata), 32'(model[a]));
    else     model[a] = d;
    $display("[TB] port%0d %s addr=%0d data=0x%02h lat=%0d", port, we ? "WR" : "RD", a,
             we ? d : (port ? p1_rdata : p0_rdata), n);
    @(posedge clk); #1;
    if (port) p1_req = 0; else p0_req = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_n"}, 32'(ram_cs_n), 32'd1);
    check({tag, "_we_n"}, 32'(ram_we_n), 32'd1);
    check({tag, "_oe_n"}, 32'(ram_oe_n), 32'd1);
    check({tag, "_acks"}, 32'({p1_ack, p0_ack}), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [1:0] order_exp [4];
    logic [1:0] order_got [4];
    int k, cyc, last_ack;

    for (int i = 0; i < 64; i++) begin
      sram[i]  = 8'($urandom);
      model[i] = sram[i];
    end
    sram[62] = 8'hFF; model[62] = 8'hFF;
    rst = 1; p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
    p0_addr = 0; p1_addr = 0; p0_wdata = 0; p1_wdata = 0;

    #1;
    check_reset_outputs("por");
    check("por_addr", 32'(ram_addr), 32'd0);
    check("por_rdata", 32'({p1_rdata, p0_rdata}), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 0;

    // Directed: read of 0xFF, then write from p1 read back on p0.
    access(0, 0, 6'd62, 8'h00);
    access(1, 1, 6'd10, 8'h5A);
    access(0, 0, 6'd10, 8'h00);

    // Randomized single-port traffic; address 63 is kept for the aborted write.
    for (int t = 0; t < 30; t++)
      access(1'($urandom), 1'($urandom), 6'($urandom_range(0, 62)), 8'($urandom));

    // Both ports requesting continuously from a freshly reset arbiter.
    @(posedge clk); #2 rst = 1;
    @(posedge clk); #2 rst = 0;
    @(posedge clk); #1;
    p0_req = 1; p0_we = 0; p0_addr = 6'd62;
    p1_req = 1; p1_we = 0; p1_addr = 6'd10;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARBITER_RR_EN
      order_exp[i] = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      order_exp[i] = 2'b01;
`endif
      order_got[i] = 2'b00;
    end
    k = 0; cyc = 0; last_ack = 0;
    while (k < 4 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (p0_ack | p1_ack) begin
        order_got[k] = {p1_ack, p0_ack};
        if (p0_ack) check("contend_p0_rdata", 32'(p0_rdata), 32'(model[62]));
        else        check("contend_p1_rdata", 32'(p1_rdata), 32'(model[10]));
        if (k > 0) check("ack_spacing", cyc - last_ack, WAIT + 4);
        $display("[TB] contend ack %0d acks=%b cycle=%0d", k, order_got[k], cyc);
        last_ack = cyc;
        k++;
      end
    end
    for (int i = 0; i < 4; i++) check("grant_order", 32'(order_got[i]), 32'(order_exp[i]));
    @(posedge clk); #1 p0_req = 0; p1_req = 0;
    repeat (WAIT + 4) @(posedge clk);

    // Reset during the strobe of a write: everything releases immediately, no ack.
    @(posedge clk); #1;
    p1_req = 1; p1_we = 1; p1_addr = 6'd63; p1_wdata = 8'hC3;
    @(posedge clk);
    @(posedge clk); #1;
    check("abort_in_strobe", 32'(ram_we_n), 32'd0);
    #2 rst = 1;
    #1;
    check_reset_outputs("abort");
    p1_req = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_ack", 32'({p1_ack, p0_ack}), 32'd0);
    end
    #2 rst = 0;
    $display("[TB] reset during write strobe released");
    check_reset_outputs("post_abort");
    access(0, 0, 6'd62, 8'h00);
    access(0, 0, 6'd10, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
